// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel push-button conditioner.
// Each channel has a 2-FF synchroniser, a stability counter that flips the held
// level after STABLE_CYCLES differing cycles, one-cycle press/release pulses and
// an optional auto-repeat pulse generator while the button stays held.
module debouncer_multi #(
    parameter int unsigned NUM_CH        = 5,
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned STABLE_CYCLES = 24'hFFFFFF,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [NUM_CH-1:0] sync_p0;
    logic [NUM_CH-1:0] sync_p1;
    logic [NUM_CH-1:0] flip;

    // Stage p0/p1: two-flop synchroniser for the raw, asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= button_in;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] stab_cnt;
        logic             level_r;
        logic             press_r;
        logic             release_r;

        // The counter holds STABLE_MAX for one cycle only after that many
        // consecutive differing samples; that cycle commits the level flip.
        assign flip[i] = (stab_cnt == STABLE_MAX);

        // Stability counter, held level and press/release pulses for this channel
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stab_cnt  <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= flip[i] && !level_r;
                release_r <= flip[i] && level_r;
                if (flip[i]) begin
                    level_r  <= ~level_r;
                    stab_cnt <= '0;
                end else if (sync_p1[i] != level_r) begin
                    stab_cnt <= stab_cnt + 1'b1;
                end else begin
                    stab_cnt <= '0;
                end
            end
        end

        assign button_level[i]  = level_r;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;

        if (REPEAT_EN != 0) begin : g_rpt
            localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

            rpt_state_t       state_q;
            rpt_state_t       state_d;
            logic [CNT_W-1:0] rcnt_q;
            logic [CNT_W-1:0] rcnt_d;
            logic             rpt_q;
            logic             rpt_d;
            logic             rise;
            logic             fall;

            // Rise/fall are taken from the flip decision so the repeat machine
            // sees a release on the same edge and never pulses on it.
            assign rise = flip[i] && !level_r;
            assign fall = flip[i] && level_r;

            // Repeat state, counter and registered repeat pulse
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= RPT_IDLE;
                    rcnt_q  <= '0;
                    rpt_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                    rpt_q   <= rpt_d;
                end
            end

            // Next-state logic: initial delay after press, then periodic repeats
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                rpt_d   = 1'b0;
                unique case (state_q)
                    RPT_IDLE: begin
                        if (rise) begin
                            state_d = RPT_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (fall) begin
                            state_d = RPT_IDLE;
                            rcnt_d  = '0;
                        end else if (rcnt_q == DELAY_LAST) begin
                            state_d = RPT_REPEAT;
                            rcnt_d  = '0;
                            rpt_d   = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (fall) begin
                            state_d = RPT_IDLE;
                            rcnt_d  = '0;
                        end else if (rcnt_q == PERIOD_LAST) begin
                            rcnt_d = '0;
                            rpt_d  = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end

            assign repeat_pulse[i] = rpt_q;
        end else begin : g_no_rpt
            assign repeat_pulse[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Testbench for debouncer_multi (4 channels, STABLE_CYCLES=4, repeat 10/5).
// A window-based reference model pushes the expected outputs for every clock
// edge into a scoreboard queue; the monitor pops and compares after the edge.
module tb_debouncer_multi;

    localparam int NCH = 4;
    localparam int S   = 4;
    localparam int D   = 10;
    localparam int P   = 5;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] button_in;
    logic [NCH-1:0] button_level;
    logic [NCH-1:0] press_pulse;
    logic [NCH-1:0] release_pulse;
    logic [NCH-1:0] repeat_pulse;

    debouncer_multi #(
        .NUM_CH(NCH),
        .CNT_W(8),
        .STABLE_CYCLES(S),
        .REPEAT_EN(1),
        .REPEAT_DELAY(D),
        .REPEAT_PERIOD(P)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_in(button_in),
        .button_level(button_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] lvl;
        logic [NCH-1:0] prs;
        logic [NCH-1:0] rel;
        logic [NCH-1:0] rpt;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // edge index since the last reset release; edge 0 is the first sampling edge
    int n;
    logic [NCH-1:0] hist [0:2047];
    logic [NCH-1:0] m_lvl;
    int m_flip  [NCH];
    int m_press [NCH];

    // observations from the DUT
    int press_edge [NCH];
    int rel_edge   [NCH];
    int first_rpt  [NCH];
    int last_rpt   [NCH];
    int press_cnt  [NCH];
    int rel_cnt    [NCH];
    int rpt_cnt    [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic sync_val(input int m, input int c);
        if (m < 2) return 1'b0;
        return hist[m-2][c];
    endfunction

    task automatic model_reset();
        n     = 0;
        m_lvl = '0;
        for (int c = 0; c < NCH; c++) begin
            m_flip[c]  = -1;
            m_press[c] = -1;
        end
        sb.delete();
    endtask

    task automatic clr_obs();
        for (int c = 0; c < NCH; c++) begin
            press_edge[c] = -1;
            rel_edge[c]   = -1;
            first_rpt[c]  = -1;
            last_rpt[c]   = -1;
            press_cnt[c]  = 0;
            rel_cnt[c]    = 0;
            rpt_cnt[c]    = 0;
        end
    endtask

    // Expected outputs after edge n: the level flips once the synchronised
    // input has differed from it on the S edges before n, all after the last flip.
    task automatic model_push(input logic [NCH-1:0] bin);
        exp_t e;
        e = '0;
        hist[n] = bin;
        for (int c = 0; c < NCH; c++) begin
            logic old_lvl, tog;
            int   d;
            old_lvl = m_lvl[c];
            tog     = 1'b0;
            if (n - S > m_flip[c]) begin
                tog = 1'b1;
                for (int m = n - S; m < n; m++)
                    if (sync_val(m, c) == old_lvl) tog = 1'b0;
            end
            if (tog) begin
                m_lvl[c]  = ~old_lvl;
                m_flip[c] = n;
                if (old_lvl) e.rel[c] = 1'b1;
                else begin
                    e.prs[c]   = 1'b1;
                    m_press[c] = n;
                end
            end
            if (old_lvl && !tog && m_press[c] >= 0) begin
                d = n - m_press[c];
                if (d == D || (d > D && ((d - D) % P) == 0)) e.rpt[c] = 1'b1;
            end
            if (old_lvl && tog) m_press[c] = -1;
        end
        e.lvl = m_lvl;
        sb.push_back(e);
    endtask

    // One cycle: drive at the falling edge, compare just after the rising edge.
    task automatic step(input logic [NCH-1:0] bin);
        exp_t e;
        button_in = bin;
        model_push(bin);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("level", button_level, e.lvl);
            chk("press", press_pulse, e.prs);
            chk("release", release_pulse, e.rel);
            chk("repeat", repeat_pulse, e.rpt);
        end
        for (int c = 0; c < NCH; c++) begin
            if (press_pulse[c]) begin
                press_edge[c] = n;
                press_cnt[c]++;
            end
            if (release_pulse[c]) begin
                rel_edge[c] = n;
                rel_cnt[c]++;
            end
            if (repeat_pulse[c]) begin
                if (rpt_cnt[c] == 0) first_rpt[c] = n;
                last_rpt[c] = n;
                rpt_cnt[c]++;
            end
        end
        n++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [NCH-1:0] bin, input int cycles);
        for (int k = 0; k < cycles; k++) step(bin);
    endtask

    // Assert reset mid-cycle, check outputs drop at once and stay low, release.
    task automatic reset_phase(input int cycles, input logic [NCH-1:0] bin);
        button_in = bin;
        reset     = 1'b1;
        #1;
        chk("rst_level", button_level, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_repeat", repeat_pulse, 0);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_out", {button_level, press_pulse, release_pulse, repeat_pulse}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int s, sr;
        reset     = 1'b1;
        button_in = '0;
        clr_obs();
        model_reset();
        @(negedge clk);

        // reset with all buttons held: all channels press together at edge 6
        reset_phase(3, 4'hF);
        clr_obs();
        drive(4'hF, 10);
        for (int c = 0; c < NCH; c++) chk("rst_press_edge", press_edge[c], 6);
        drive(4'h0, 12);

        // clean press/release on ch0
        clr_obs();
        s = n;
        drive(4'h1, 12);
        sr = n;
        drive(4'h0, 10);
        chk("ch0_press_lat", press_edge[0] - s, 6);
        chk("ch0_rel_lat", rel_edge[0] - sr, 6);

        // short glitch on ch1 must be ignored
        clr_obs();
        drive(4'h2, 3);
        drive(4'h0, 10);
        chk("ch1_glitch_pulses", press_cnt[1] + rel_cnt[1], 0);

        // bounce 1,0,1,1,1,1 on ch1: press after four consecutive highs
        clr_obs();
        s = n;
        step(4'h2);
        step(4'h0);
        drive(4'h2, 8);
        drive(4'h0, 10);
        chk("ch1_bounce_lat", press_edge[1] - (s + 2), 6);
        chk("ch1_bounce_presses", press_cnt[1], 1);

        // auto-repeat on ch2: repeats at press+10, +15, +20, +25, +30
        clr_obs();
        s = n;
        drive(4'h4, 31);
        sr = n;
        drive(4'h0, 12);
        chk("ch2_press_lat", press_edge[2] - s, 6);
        chk("ch2_first_rpt", first_rpt[2] - press_edge[2], D);
        chk("ch2_last_rpt", last_rpt[2] - press_edge[2], 30);
        chk("ch2_rpt_cnt", rpt_cnt[2], 5);
        chk("ch2_rel_lat", rel_edge[2] - sr, 6);

        // ch0 clean, ch3 bouncing, both starting on the same cycle
        clr_obs();
        s = n;
        step(4'h9);
        step(4'h1);
        step(4'h9);
        step(4'h1);
        drive(4'h9, 10);
        drive(4'h0, 10);
        chk("indep_ch0_lat", press_edge[0] - s, 6);
        chk("indep_ch3_lat", press_edge[3] - s, 10);

        // reset while ch2 is repeating, button kept held through reset
        clr_obs();
        drive(4'h4, 22);
        chk("pre_rst_rpt_cnt", rpt_cnt[2], 2);
        reset_phase(3, 4'h4);
        clr_obs();
        drive(4'h4, 25);
        chk("post_rst_press", press_edge[2], 6);
        chk("post_rst_first_rpt", first_rpt[2], 16);
        chk("post_rst_no_release", rel_cnt[2], 0);
        drive(4'h0, 12);
        chk("post_rst_rel_cnt", rel_cnt[2], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised N-channel button conditioner; successor to the single-threshold 5-button debouncer.
- Per-channel synchroniser, independent stability counter and held-level output.
- One-cycle press/release pulses per channel, plus optional auto-repeat pulses while a button is held.
- Sits between board push-buttons/switches and the control FSMs on the 100 MHz Basys 3 clock.

Parameters:
- NUM_CH, 5, number of independent input channels (>=1)
- CNT_W, 27, width of the stability and repeat counters
- STABLE_CYCLES, 24'hFFFFFF, consecutive cycles an input must differ from its level before the level flips (1 .. 2^CNT_W-1)
- REPEAT_EN, 0, 1 enables auto-repeat pulses; 0 ties repeat_pulse to 0 and removes the repeat logic
- REPEAT_DELAY, 50_000_000, held cycles from the press pulse to the first repeat pulse (>=1)
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (>=1)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- button_in  in  NUM_CH  raw, asynchronous button inputs
- button_level  out  NUM_CH  debounced held state per channel
- press_pulse  out  NUM_CH  1-cycle pulse on a debounced 0->1 transition
- release_pulse  out  NUM_CH  1-cycle pulse on a debounced 1->0 transition
- repeat_pulse  out  NUM_CH  1-cycle auto-repeat pulse while held (REPEAT_EN=1 only)

Behaviour:
- Clock and reset: one clock domain. The reset is asynchronous and active-high. It clears every register: sync flops, counters, levels and pulses.
- Reset values: all outputs are 0 while reset is asserted and on the first clock edge after release.
- Synchroniser: 2-FF per channel; sync[i] is button_in[i] delayed by 2 cycles.
- Stability counter, per channel, all channels independent:
  - sync[i] == button_level[i]: counter clears to 0.
  - otherwise: counter increments.
  - On the edge where the counter would reach STABLE_CYCLES: button_level[i] toggles, the counter clears to 0, and press_pulse[i] (new level 1) or release_pulse[i] (new level 0) is asserted for exactly that one cycle.
- Latency: a clean step on button_in[i] shows on button_level[i] and the pulse output exactly STABLE_CYCLES+2 cycles after the first sampling edge.
- Glitch rejection: any excursion shorter than STABLE_CYCLES cycles at sync[i] clears the counter on return. No level change, no pulse.
- Counter arithmetic: unsigned, CNT_W bits. It never saturates or wraps, because it clears at STABLE_CYCLES <= 2^CNT_W-1.
- Repeat state machine, per channel, when REPEAT_EN=1:
  - IDLE: level 0. Go to DELAY on the press pulse and load the repeat counter with 0.
  - DELAY: count held cycles. When the count reaches REPEAT_DELAY, emit repeat_pulse, clear the count and go to REPEAT.
  - REPEAT: when the count reaches REPEAT_PERIOD, emit repeat_pulse and clear the count.
  - Release (level falling) from DELAY or REPEAT returns to IDLE immediately with the count cleared. No repeat pulse is issued on the release cycle.
- Pulse exclusivity: press_pulse, release_pulse and repeat_pulse are never asserted together on one channel.
- Simultaneous events: several channels may pulse on the same cycle. Each channel's timing is unaffected by the others.
- Reset mid-operation: counters, levels and repeat states drop to 0/IDLE asynchronously. No release_pulse is generated for a channel that was held.
- Registered outputs: all outputs come from registers, with no combinational path from button_in.

Test Plan (NUM_CH=4, STABLE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Reset: assert reset with button_in=4'hF and hold, then release -> all outputs 0 during reset; button_level=4'hF and press_pulse=4'hF for one cycle at 6 cycles after the first sampling edge.
- Clean press: ch0 step 0->1 -> button_level[0] rises and press_pulse[0]=1 for 1 cycle exactly 6 cycles later; release 0->1->0 gives release_pulse[0] with the same 6-cycle latency.
- Glitch: ch1 high for 3 cycles then low -> button_level[1], press_pulse[1] and release_pulse[1] stay 0. Bounce pattern 1,0,1,1,1,1 -> press only after 4 consecutive highs.
- Auto-repeat: ch2 held 30 cycles -> press at t, repeats at t+10, t+15, t+20, t+25, t+30 while held; on release, repeat stops and release_pulse[2] follows 6 cycles after the edge.
- Independence: ch0 and ch3 pressed on the same cycle, ch3 bouncing -> ch0 pulses at +6; ch3 pulses only after its own 4 stable cycles.
- Reset mid-hold: ch2 in REPEAT, then assert reset -> all outputs 0 immediately, no release_pulse; after deassert with the button still held, a fresh press pulse comes 6 cycles later and the repeat timing restarts from REPEAT_DELAY.
